piu_ctrl_bp: RTL and testbench

- Parametrised, sequential successor of the PIU control path. It owns the PIU state register, the opcode register and the patch-index scan register.
- Each cycle it walks the selected patch bitmask lowest index first. Issue to PSU and LMU uses valid/ready backpressure, and back-to-back PDU instructions are accepted without a bubble.
- It sits between the PDU instruction stream and the PSU/LMU. It also drives the dyninfo write strobes for the PIU memories.

---
 rtl/piu_ctrl_bp.sv | 138 +++++++++++++
 tb/tb_piu_ctrl_bp.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/piu_ctrl_bp.sv
// PIU control path with valid/ready backpressure toward PSU/LMU.
// Walks the selected patch bitmask lowest index first, one patch per cycle,
// and accepts the next PDU instruction in the same cycle the last patch
// advances so consecutive instructions issue without a bubble.
module piu_ctrl_bp #(
  parameter int NUM_PCH    = 20,
  parameter int PCHADDR_BW = $clog2(NUM_PCH),
  parameter int OPCODE_BW  = 4,
  parameter int MT_PCHIDX  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pdu_valid,
  input  logic [OPCODE_BW-1:0]  opcode,
  input  logic [NUM_PCH-1:0]    pchlist_mask,
  input  logic [NUM_PCH-1:0]    esmon_mask,
  input  logic [NUM_PCH-1:0]    merged_mask,
  output logic                  pdu_ready,
  input  logic                  psu_ready,
  input  logic                  lmu_ready,
  output logic                  topsu_valid,
  output logic                  tolmu_valid,
  output logic [PCHADDR_BW-1:0] pchidx,
  output logic [OPCODE_BW-1:0]  opcode_reg,
  output logic                  last_pchinfo,
  output logic                  is_writing,
  output logic                  prep_dyninfo,
  output logic                  split_dyninfo,
  output logic                  set_merged,
  output logic                  copy_merged,
  output logic                  mgdmem_wren,
  output logic [1:0]            state
);

  // Opcode encodings shared with the PDU instruction format.
  localparam logic [OPCODE_BW-1:0] OP_LQI        = OPCODE_BW'(1);
  localparam logic [OPCODE_BW-1:0] OP_LQM_X      = OPCODE_BW'(2);
  localparam logic [OPCODE_BW-1:0] OP_LQM_Z      = OPCODE_BW'(3);
  localparam logic [OPCODE_BW-1:0] OP_LQM_Y      = OPCODE_BW'(4);
  localparam logic [OPCODE_BW-1:0] OP_RUN_ESM    = OPCODE_BW'(5);
  localparam logic [OPCODE_BW-1:0] OP_INIT_INTMD = OPCODE_BW'(6);
  localparam logic [OPCODE_BW-1:0] OP_MEAS_INTMD = OPCODE_BW'(7);
  localparam logic [OPCODE_BW-1:0] OP_PPM_INTERP = OPCODE_BW'(8);
  localparam logic [OPCODE_BW-1:0] OP_MERGE_INFO = OPCODE_BW'(9);
  localparam logic [OPCODE_BW-1:0] OP_PREP_INFO  = OPCODE_BW'(10);
  localparam logic [OPCODE_BW-1:0] OP_SPLIT_INFO = OPCODE_BW'(11);

  localparam logic [1:0] ST_READY     = 2'd0;
  localparam logic [1:0] ST_READING   = 2'd1;
  localparam logic [1:0] ST_WRITING   = 2'd2;
  localparam logic [1:0] ST_RESETTING = 2'd3;

  logic [NUM_PCH-1:0]   scan, scan_nxt, scan_clr;
  logic [1:0]           state_nxt;
  logic [OPCODE_BW-1:0] opcode_nxt;
  logic                 scan_any, scan_onehot, advance, accept;

  // scan & (scan-1) drops the lowest set bit, i.e. the patch at pchidx.
  assign scan_clr    = scan & (scan - NUM_PCH'(1));
  assign scan_any    = |scan;
  assign scan_onehot = scan_any && (scan_clr == '0);

  // State, opcode and scan registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_READY;
      scan       <= '0;
      opcode_reg <= '0;
    end else begin
      state      <= state_nxt;
      scan       <= scan_nxt;
      opcode_reg <= opcode_nxt;
    end
  end

  // Next state: load a new instruction on accept, otherwise retire patches.
  always_comb begin
    state_nxt  = state;
    scan_nxt   = scan;
    opcode_nxt = opcode_reg;
    if (accept) begin
      opcode_nxt = opcode;
      unique case (opcode)
        OP_RUN_ESM:                                 scan_nxt = esmon_mask;
        OP_INIT_INTMD, OP_MEAS_INTMD, OP_PPM_INTERP: scan_nxt = merged_mask;
        OP_MERGE_INFO, OP_LQI, OP_LQM_X, OP_LQM_Z, OP_LQM_Y:
                                                    scan_nxt = pchlist_mask;
        default:                                    scan_nxt = '0;
      endcase
      unique case (opcode)
        OP_MERGE_INFO:              state_nxt = ST_WRITING;
        OP_PREP_INFO, OP_SPLIT_INFO: state_nxt = ST_RESETTING;
        default:                    state_nxt = ST_READING;
      endcase
    end else begin
      if ((state == ST_READING || state == ST_WRITING) && advance)
        scan_nxt = scan_clr;
      if (state == ST_RESETTING)
        state_nxt = ST_READY;
      else if ((state == ST_READING || state == ST_WRITING) && scan_nxt == '0)
        state_nxt = ST_READY;
    end
  end

  // Outputs: patch select, issue mapping, handshake and dyninfo strobes.
  always_comb begin
    pchidx = '0;
    for (int i = NUM_PCH - 1; i >= 0; i--)
      if (scan[i]) pchidx = PCHADDR_BW'(i);

    topsu_valid = 1'b0;
    tolmu_valid = 1'b0;
    if (state == ST_READING && scan_any) begin
      unique case (opcode_reg)
        OP_LQI:                           topsu_valid = (pchidx != PCHADDR_BW'(MT_PCHIDX));
        OP_LQM_X, OP_LQM_Z, OP_LQM_Y:     begin topsu_valid = 1'b1; tolmu_valid = 1'b1; end
        OP_RUN_ESM, OP_INIT_INTMD, OP_MEAS_INTMD: topsu_valid = 1'b1;
        OP_PPM_INTERP:                    tolmu_valid = 1'b1;
        default: ;
      endcase
    end

    advance = (!topsu_valid || psu_ready) && (!tolmu_valid || lmu_ready);
    accept  = pdu_valid && (state == ST_READY || state == ST_RESETTING ||
                            !scan_any || (scan_onehot && advance));
    pdu_ready = accept;

    last_pchinfo  = (state == ST_READING) && scan_onehot;
    is_writing    = (state == ST_WRITING);
    mgdmem_wren   = (state == ST_WRITING) && scan_any;
    prep_dyninfo  = (state == ST_RESETTING) && (opcode_reg == OP_PREP_INFO);
    split_dyninfo = (state == ST_RESETTING) && (opcode_reg == OP_SPLIT_INFO);
    set_merged    = accept && (opcode == OP_MERGE_INFO);
    copy_merged   = accept && (opcode == OP_INIT_INTMD || opcode == OP_MEAS_INTMD ||
                               opcode == OP_PPM_INTERP);
  end

endmodule

// File: tb/tb_piu_ctrl_bp.sv
// Directed bench for piu_ctrl_bp: issue order, LQI masking, stalls,
// back-to-back accept, merge writes, resetting pulse and mid-instruction reset.
module tb_piu_ctrl_bp;
  localparam int NUM_PCH = 20;
  localparam int PBW     = $clog2(NUM_PCH);
  localparam int OBW     = 4;

  localparam logic [3:0] LQI = 4'd1, LQM_X = 4'd2, LQM_Z = 4'd3, LQM_Y = 4'd4,
                         RUN_ESM = 4'd5, INIT_INTMD = 4'd6, PPM = 4'd8,
                         MERGE_INFO = 4'd9, PREP_INFO = 4'd10, SPLIT_INFO = 4'd11;

  logic clk = 1'b0, rst;
  logic pdu_valid, psu_ready, lmu_ready;
  logic [OBW-1:0] opcode;
  logic [NUM_PCH-1:0] pchlist_mask, esmon_mask, merged_mask;
  logic pdu_ready, topsu_valid, tolmu_valid, last_pchinfo, is_writing;
  logic prep_dyninfo, split_dyninfo, set_merged, copy_merged, mgdmem_wren;
  logic [PBW-1:0] pchidx;
  logic [OBW-1:0] opcode_reg;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  piu_ctrl_bp dut (
    .clk(clk), .rst(rst), .pdu_valid(pdu_valid), .opcode(opcode),
    .pchlist_mask(pchlist_mask), .esmon_mask(esmon_mask), .merged_mask(merged_mask),
    .pdu_ready(pdu_ready), .psu_ready(psu_ready), .lmu_ready(lmu_ready),
    .topsu_valid(topsu_valid), .tolmu_valid(tolmu_valid), .pchidx(pchidx),
    .opcode_reg(opcode_reg), .last_pchinfo(last_pchinfo), .is_writing(is_writing),
    .prep_dyninfo(prep_dyninfo), .split_dyninfo(split_dyninfo),
    .set_merged(set_merged), .copy_merged(copy_merged),
    .mgdmem_wren(mgdmem_wren), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step past the next rising edge; inputs are changed after this, checks 1ns later.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input string tag, input logic ts, input logic tl,
                       input logic [31:0] idx, input logic last);
    chk({tag, ".topsu"}, 32'(topsu_valid), 32'(ts));
    chk({tag, ".tolmu"}, 32'(tolmu_valid), 32'(tl));
    chk({tag, ".pchidx"}, 32'(pchidx), idx);
    chk({tag, ".last"}, 32'(last_pchinfo), 32'(last));
  endtask

  task automatic all_zero(input string tag);
    chk({tag, ".outs"}, {20'd0, pdu_ready, topsu_valid, tolmu_valid, last_pchinfo,
         is_writing, prep_dyninfo, split_dyninfo, set_merged, copy_merged,
         mgdmem_wren, state}, 32'd0);
    chk({tag, ".pchidx"}, 32'(pchidx), 32'd0);
    chk({tag, ".opreg"}, 32'(opcode_reg), 32'd0);
  endtask

  // Present an instruction in a cycle where the DUT is expected to take it.
  task automatic send(input logic [3:0] op, input logic [NUM_PCH-1:0] m, input string tag);
    pdu_valid = 1'b1; opcode = op;
    pchlist_mask = m; esmon_mask = m; merged_mask = m;
    #1 chk({tag, ".pdu_ready"}, 32'(pdu_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; pdu_valid = 1'b0; opcode = '0; psu_ready = 1'b1; lmu_ready = 1'b1;
    pchlist_mask = '0; esmon_mask = '0; merged_mask = '0;
    tick(); tick();
    rst = 1'b0;
    #1 all_zero("reset");

    // LQM_X 0b1010: pchidx 1 then 3, READY on the third cycle
    send(LQM_X, 20'b1010, "lqmx");
    tick(); pdu_valid = 1'b0; #1 issue("lqmx.c1", 1, 1, 1, 0);
    chk("lqmx.state", 32'(state), 32'd1);
    tick(); #1 issue("lqmx.c2", 1, 1, 3, 1);
    tick(); #1 chk("lqmx.ready", 32'(state), 32'd0);
    chk("lqmx.idle", 32'(topsu_valid), 32'd0);

    // LQI 0b0110: masked patch 1, then patch 2 to PSU
    send(LQI, 20'b0110, "lqi");
    tick(); pdu_valid = 1'b0; #1 issue("lqi.c1", 0, 0, 1, 0);
    chk("lqi.opreg", 32'(opcode_reg), 32'(LQI));
    tick(); #1 issue("lqi.c2", 1, 0, 2, 1);
    tick(); #1 chk("lqi.ready", 32'(state), 32'd0);

    // RUN_ESM 0b1 with psu_ready low for 3 cycles
    psu_ready = 1'b0;
    send(RUN_ESM, 20'b1, "esm");
    tick(); pdu_valid = 1'b0; #1 issue("esm.s1", 1, 0, 0, 1);
    tick(); #1 issue("esm.s2", 1, 0, 0, 1);
    tick(); #1 issue("esm.s3", 1, 0, 0, 1);
    tick(); psu_ready = 1'b1; #1 issue("esm.go", 1, 0, 0, 1);
    tick(); #1 chk("esm.ready", 32'(state), 32'd0);
    chk("esm.done", 32'(topsu_valid), 32'd0);

    // LQM_Z 0b11 followed back-to-back by LQM_Z 0b100
    send(LQM_Z, 20'b11, "b2b");
    tick(); pchlist_mask = 20'b100; #1 issue("b2b.c1", 1, 1, 0, 0);
    chk("b2b.hold", 32'(pdu_ready), 32'd0);
    tick(); #1 issue("b2b.c2", 1, 1, 1, 1);
    chk("b2b.accept", 32'(pdu_ready), 32'd1);
    tick(); pdu_valid = 1'b0; #1 issue("b2b.c3", 1, 1, 2, 1);
    tick(); #1 chk("b2b.ready", 32'(state), 32'd0);

    // MERGE_INFO 0b101: set_merged on accept, two memory writes
    send(MERGE_INFO, 20'b101, "mrg");
    chk("mrg.set", 32'(set_merged), 32'd1);
    tick(); pdu_valid = 1'b0; #1 chk("mrg.w1", {mgdmem_wren, is_writing, 3'd0, pchidx}, {2'b11, 8'd0});
    chk("mrg.set_off", 32'(set_merged), 32'd0);
    tick(); #1 chk("mrg.w2", {mgdmem_wren, is_writing, 3'd0, pchidx}, {2'b11, 8'd2});
    tick(); #1 chk("mrg.done", {mgdmem_wren, is_writing, state}, 4'd0);

    // INIT_INTMD from merged set, PPM_INTERPRET goes to LMU only
    send(INIT_INTMD, 20'b10000, "ini");
    chk("ini.copy", 32'(copy_merged), 32'd1);
    tick(); pdu_valid = 1'b0; #1 issue("ini.c1", 1, 0, 4, 1);
    tick();
    send(PPM, 20'h80000, "ppm");
    tick(); pdu_valid = 1'b0; #1 issue("ppm.c1", 0, 1, 19, 1);
    tick();

    // Empty mask: READING for one cycle without valids
    send(LQM_X, 20'b0, "empty");
    tick(); pdu_valid = 1'b0; #1 chk("empty.st", {state, topsu_valid, tolmu_valid}, {2'd1, 2'b00});
    tick(); #1 chk("empty.ready", 32'(state), 32'd0);

    // PREP_INFO and SPLIT_INFO: one RESETTING cycle with the matching pulse
    send(PREP_INFO, 20'b0, "prep");
    tick(); pdu_valid = 1'b0; #1 chk("prep.st", {state, prep_dyninfo, split_dyninfo}, {2'd3, 2'b10});
    tick(); #1 chk("prep.done", {state, prep_dyninfo}, 3'd0);
    send(SPLIT_INFO, 20'b0, "split");
    tick(); pdu_valid = 1'b0; #1 chk("split.st", {state, prep_dyninfo, split_dyninfo}, {2'd3, 2'b01});
    tick();

    // LQM_Y stalled by LMU, then reset mid-instruction
    lmu_ready = 1'b0;
    send(LQM_Y, 20'b111, "rst");
    tick(); pdu_valid = 1'b0; #1 issue("rst.c1", 1, 1, 0, 0);
    tick(); #1 issue("rst.stall", 1, 1, 0, 0);
    rst = 1'b1;
    tick(); rst = 1'b0; lmu_ready = 1'b1; #1 all_zero("rst.mid");
    tick(); #1 chk("rst.after", {topsu_valid, tolmu_valid, state}, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
